// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I opcodes, access-size
// encodings, FSM states and the alignment rule used by the trap option.
package load_store_unit_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } lsu_state_e;

    // Undefined size codes fall back to word, so they need word alignment.
    // For stores, 100/101 are undefined and therefore word-sized.
    function automatic logic misaligned_access(input logic       is_load,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_B:    mis = 1'b0;
            F3_H:    mis = off[0];
            F3_BU:   mis = is_load ? 1'b0 : (off != 2'b00);
            F3_HU:   mis = is_load ? off[0] : (off != 2'b00);
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the memory system (slave).
interface load_store_unit_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_be, mem_read, mem_write,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_be, mem_read, mem_write,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Lane handling for the load/store unit: byte-enable and lane-replicated
// write data for the store path, lane extraction and sign/zero extension
// for the load path. Purely combinational.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store path: loads always enable the full word; undefined sizes act as SW.
    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        if (is_load) begin
            be    = 4'b1111;
            wdata = st_data;
        end else begin
            case (st_funct3)
                F3_B: begin
                    be    = 4'b0001 << st_offset;
                    wdata = {4{st_data[7:0]}};
                end
                F3_H: begin
                    be    = st_offset[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{st_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = st_data;
                end
            endcase
        end
    end

    // Load path: pick the addressed lane, then extend to 32 bits.
    always_comb begin
        case (ld_offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        half_s = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_s[7]}}, byte_s};
            F3_H:    ld_data = {{16{half_s[15]}}, half_s};
            F3_BU:   ld_data = {24'h000000, byte_s};
            F3_HU:   ld_data = {16'h0000, half_s};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one request/acknowledge transaction per load or
// store, stalls the core while it is outstanding, aborts after
// TIMEOUT_CYCLES without an acknowledge and returns extended load data
// for writeback.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses skip the
// bus and pulse the extra 'misaligned' output).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic [31:0] load_data,
    output logic [4:0]  load_rd,
    output logic        load_valid,
    output logic        freeze,
    output logic        bus_error,
`ifdef MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    load_store_unit_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       funct3_r;
    logic [1:0]       offset_r;
    logic [4:0]       rd_r;

    logic        is_load_s;
    logic        is_store_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ld_data_s;

    assign is_load_s  = (opcode == OPC_LOAD);
    assign is_store_s = (opcode == OPC_STORE);

`ifdef MISALIGN_TRAP_EN
    logic mis_s;

    // Alignment check of the incoming access against its size.
    always_comb begin
        mis_s = misaligned_access(is_load_s, funct3, address[1:0]);
    end
`endif

    // Store lanes come from the live instruction (captured at launch);
    // load extraction uses the size/offset latched at launch.
    load_store_unit_align u_align (
        .is_load   (is_load_s),
        .st_funct3 (funct3),
        .st_offset (address[1:0]),
        .st_data   (store_data),
        .be        (be_s),
        .wdata     (wdata_s),
        .ld_funct3 (funct3_r),
        .ld_offset (offset_r),
        .rdata     (bus.mem_rdata),
        .ld_data   (ld_data_s)
    );

    // Stall: asserted as soon as a memory opcode shows up in IDLE and held
    // through the request; held low in reset so the core is never frozen by it.
    always_comb begin
        freeze = 1'b0;
        if (rst) begin
            freeze = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:           freeze = is_load_s | is_store_s;
                ST_READ, ST_WRITE: freeze = 1'b1;
                default:           freeze = 1'b0;
            endcase
        end
    end

    // Transaction FSM, launch latches, timeout counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            funct3_r      <= 3'b000;
            offset_r      <= 2'b00;
            rd_r          <= 5'd0;
            load_data     <= 32'h0000_0000;
            load_rd       <= 5'd0;
            load_valid    <= 1'b0;
            bus_error     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned    <= 1'b0;
`endif
            bus.mem_addr  <= 32'h0000_0000;
            bus.mem_wdata <= 32'h0000_0000;
            bus.mem_be    <= 4'b0000;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (is_load_s || is_store_s) begin
                        funct3_r      <= funct3;
                        offset_r      <= address[1:0];
                        rd_r          <= rd;
                        bus.mem_addr  <= {address[31:2], 2'b00};
                        bus.mem_be    <= be_s;
                        bus.mem_wdata <= wdata_s;
`ifdef MISALIGN_TRAP_EN
                        if (mis_s) begin
                            misaligned <= 1'b1;
                            state_r    <= ST_DONE;
                        end else if (is_load_s) begin
                            bus.mem_read <= 1'b1;
                            state_r      <= ST_READ;
                        end else begin
                            bus.mem_write <= 1'b1;
                            state_r       <= ST_WRITE;
                        end
`else
                        if (is_load_s) begin
                            bus.mem_read <= 1'b1;
                            state_r      <= ST_READ;
                        end else begin
                            bus.mem_write <= 1'b1;
                            state_r       <= ST_WRITE;
                        end
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (bus.mem_ack) begin
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        if (state_r == ST_READ) begin
                            load_data  <= ld_data_s;
                            load_rd    <= rd_r;
                            load_valid <= 1'b1;
                        end else begin
                            load_valid <= 1'b0;
                        end
                        state_r <= ST_DONE;
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        bus_error     <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
